// File: rtl/mul32_booth_seq_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_ITERS = (MUL_WIDTH + 2) / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } pp_sel_e;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic pp_sel_e booth_sel(input logic [2:0] win);
        pp_sel_e sel;
        unique case (win)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mul32_booth_seq_if.sv
// Issue/result interface between the reservation station and the multiply unit.
interface mul32_booth_seq_if;
    import mul_pkg::*;

    logic                 in_en;
    logic [MUL_WIDTH-1:0] a;
    logic [MUL_WIDTH-1:0] b;
    logic                 a_signed;
    logic                 b_signed;
    logic                 out_en;
    logic                 idle;
    logic [MUL_WIDTH-1:0] sum_hi;
    logic [MUL_WIDTH-1:0] sum_lo;

    modport master (
        output in_en, a, b, a_signed, b_signed,
        input  out_en, idle, sum_hi, sum_lo
    );

    modport slave (
        input  in_en, a, b, a_signed, b_signed,
        output out_en, idle, sum_hi, sum_lo
    );

endinterface

// File: rtl/mul32_booth_seq_booth_r4_pp.sv
// Radix-4 Booth partial-product generator: selects 0, +-ea or +-2ea from a 3-bit window.
module booth_r4_pp
    import mul_pkg::*;
(
    input  logic [2:0]           win_i,
    input  logic [MUL_WIDTH:0]   ea_i,
    output logic [MUL_WIDTH+2:0] pp_o
);

    logic [MUL_WIDTH+2:0] ea1;
    logic [MUL_WIDTH+2:0] ea2;

    assign ea1 = {{2{ea_i[MUL_WIDTH]}}, ea_i};
    assign ea2 = {ea_i[MUL_WIDTH], ea_i, 1'b0};

    always_comb begin
        pp_o = '0;
        unique case (booth_sel(win_i))
            PP_POS1: pp_o = ea1;
            PP_POS2: pp_o = ea2;
            PP_NEG1: pp_o = -ea1;
            PP_NEG2: pp_o = -ea2;
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/mul32_booth_seq.sv
// Iterative radix-4 Booth multiplier, 32x32 -> 64, one Booth digit per cycle.
module mul32_booth_seq
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mul32_booth_seq_if.slave    bus
);

    localparam int unsigned EW = MUL_WIDTH + 1;
    localparam int unsigned MW = MUL_WIDTH + 3;
    localparam int unsigned AW = 2 * MUL_WIDTH + 4;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LastIter = CW'(MUL_ITERS - 1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EW-1:0]        ea_q, ea_d;
    logic [MW-1:0]        mr_q, mr_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic                 out_en_q, out_en_d;
    logic [MUL_WIDTH-1:0] sum_hi_q, sum_hi_d;
    logic [MUL_WIDTH-1:0] sum_lo_q, sum_lo_d;

    logic [EW-1:0]        ea_in;
    logic [EW-1:0]        eb_in;
    logic [MW-1:0]        pp;
    logic signed [AW+1:0] acc_wide;
    logic [AW-1:0]        acc_next;

    assign ea_in = {bus.a_signed & bus.a[MUL_WIDTH-1], bus.a};
    assign eb_in = {bus.b_signed & bus.b[MUL_WIDTH-1], bus.b};

    booth_r4_pp u_pp (
        .win_i (mr_q[2:0]),
        .ea_i  (ea_q),
        .pp_o  (pp)
    );

    // Partial product enters at weight 2^34, then the whole accumulator shifts down a digit.
    assign acc_wide = $signed({{2{acc_q[AW-1]}}, acc_q})
                    + $signed({pp[MW-1], pp, 34'b0});
    assign acc_next = AW'(acc_wide >>> 2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ea_d     = ea_q;
        mr_d     = mr_q;
        acc_d    = acc_q;
        out_en_d = 1'b0;
        sum_hi_d = sum_hi_q;
        sum_lo_d = sum_lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_en) begin
                    ea_d    = ea_in;
                    mr_d    = {eb_in[EW-1], eb_in, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_next;
                mr_d  = {{2{mr_q[MW-1]}}, mr_q[MW-1:2]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d  = DONE;
                    out_en_d = 1'b1;
                    sum_hi_d = acc_next[2*MUL_WIDTH-1:MUL_WIDTH];
                    sum_lo_d = acc_next[MUL_WIDTH-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ea_q     <= '0;
            mr_q     <= '0;
            acc_q    <= '0;
            out_en_q <= 1'b0;
            sum_hi_q <= '0;
            sum_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ea_q     <= ea_d;
            mr_q     <= mr_d;
            acc_q    <= acc_d;
            out_en_q <= out_en_d;
            sum_hi_q <= sum_hi_d;
            sum_lo_q <= sum_lo_d;
        end
    end

    // Drops combinationally with in_en so a same-edge issuer cannot double-issue.
    assign bus.idle   = (state_q == IDLE) && !bus.in_en;
    assign bus.out_en = out_en_q;
    assign bus.sum_hi = sum_hi_q;
    assign bus.sum_lo = sum_lo_q;

endmodule

// File: tb/tb_mul32_booth_seq.sv
// Self-checking bench for mul32_booth_seq: scoreboard of expected products per issue.
module tb_mul32_booth_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul32_booth_seq_if bus ();

    mul32_booth_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    logic [63:0] sb_q[$];

    always @(negedge clk) if (bus.out_en === 1'b1) pulses++;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (got running, need finished)");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic as, input logic bs);
        logic [32:0] ea;
        logic [32:0] eb;
        logic signed [65:0] pa;
        logic signed [65:0] pb;
        logic signed [65:0] prod;
        ea   = {as & a[31], a};
        eb   = {bs & b[31], b};
        pa   = $signed({{33{ea[32]}}, ea});
        pb   = $signed({{33{eb[32]}}, eb});
        prod = pa * pb;
        return prod[63:0];
    endfunction

    // Called just after a posedge; the following edge is the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic as,
                         input logic bs, input logic [63:0] exp_prod);
        n_vec++;
        if (bus.idle !== 1'b1) begin
            n_err++;
            $display("FAIL issue_idle: idle=%b need 1", bus.idle);
        end
        bus.a        = a;
        bus.b        = b;
        bus.a_signed = as;
        bus.b_signed = bs;
        bus.in_en    = 1'b1;
        sb_q.push_back(exp_prod);
        @(posedge clk);
        #1;
        bus.in_en = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.a_signed = 1'($urandom_range(0, 1));
        bus.b_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int lat;
        logic [63:0] exp_prod;
        lat = -1;
        for (int j = 0; j <= 40; j++) begin
            @(negedge clk);
            if (bus.out_en === 1'b1) begin
                lat = j;
                break;
            end
            @(posedge clk);
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d need %0d", name, lat, exp_lat);
        end
        if (lat >= 0) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL %s_unexpected: out_en with empty scoreboard, got %h_%h",
                         name, bus.sum_hi, bus.sum_lo);
            end else begin
                exp_prod = sb_q.pop_front();
                if ({bus.sum_hi, bus.sum_lo} !== exp_prod) begin
                    n_err++;
                    $display("FAIL %s_product: got %h_%h need %h_%h", name, bus.sum_hi,
                             bus.sum_lo, exp_prod[63:32], exp_prod[31:0]);
                end
            end
            n_vec++;
            if (bus.idle !== 1'b0) begin
                n_err++;
                $display("FAIL %s_idle_done: idle=%b need 0", name, bus.idle);
            end
        end else if (sb_q.size() != 0) begin
            void'(sb_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.out_en !== 1'b0 || bus.idle !== 1'b1) begin
            n_err++;
            $display("FAIL %s_after: out_en=%b idle=%b need 0 1", name, bus.out_en, bus.idle);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.in_en = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.a_signed = 1'b0;
        bus.b_signed = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.idle !== 1'b1 || bus.out_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: idle=%b out_en=%b need 1 0", bus.idle, bus.out_en);
        end
        n_vec++;
        if (bus.sum_hi !== 32'h0 || bus.sum_lo !== 32'h0) begin
            n_err++;
            $display("FAIL reset_sums: got %h_%h need 0_0", bus.sum_hi, bus.sum_lo);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.in_en = 1'b1;
        #1;
        n_vec++;
        if (bus.idle !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_drop: idle=%b need 0", bus.idle);
        end
        bus.in_en = 1'b0;
        #1;
        n_vec++;
        if (bus.idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle_back: idle=%b need 1", bus.idle);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int p0;
        p0 = pulses;
        issue(32'd7, 32'd6, 1'b0, 1'b0, 64'd42);
        wait_result("basic", 17);
        n_vec++;
        if (pulses - p0 != 1) begin
            n_err++;
            $display("FAIL basic_pulses: got %0d need 1", pulses - p0);
        end
    endtask

    task automatic test_signedness();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
        wait_result("ss_m1", 17);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
        wait_result("uu_max", 17);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
        wait_result("su_m1", 17);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
        wait_result("ss_min", 17);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000);
        wait_result("su_min", 17);
    endtask

    task automatic test_busy_drop();
        int p0;
        p0 = pulses;
        issue(32'd3, 32'd5, 1'b0, 1'b0, 64'd15);
        repeat (4) @(posedge clk);
        #1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.in_en = 1'b1;
        @(posedge clk);
        #1;
        bus.in_en = 1'b0;
        wait_result("busy_drop", 12);
        repeat (25) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (pulses - p0 != 1) begin
            n_err++;
            $display("FAIL busy_drop_pulses: got %0d need 1", pulses - p0);
        end
        n_vec++;
        if (bus.sum_hi !== 32'h0 || bus.sum_lo !== 32'd15) begin
            n_err++;
            $display("FAIL busy_drop_hold: got %h_%h need 0_f", bus.sum_hi, bus.sum_lo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int p0;
        p0 = pulses;
        issue(32'd100, 32'd100, 1'b0, 1'b0, 64'd10000);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (pulses != p0) begin
            n_err++;
            $display("FAIL midop_pulses: got %0d need 0", pulses - p0);
        end
        n_vec++;
        if (bus.sum_hi !== 32'h0 || bus.sum_lo !== 32'h0 || bus.idle !== 1'b1) begin
            n_err++;
            $display("FAIL midop_state: sums %h_%h idle=%b need 0_0 1", bus.sum_hi,
                     bus.sum_lo, bus.idle);
        end
        @(posedge clk);
        #1;
        issue(32'd2, 32'd3, 1'b0, 1'b0, 64'd6);
        wait_result("midop_next", 17);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic as;
        logic bs;
        for (int i = 0; i < 16; i++) begin
            a  = $urandom;
            b  = $urandom;
            as = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
            issue(a, b, as, bs, model(a, b, as, bs));
            wait_result("b2b", 17);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signedness();
        test_busy_drop();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
